adc_serial_rx_multi: RTL and testbench
======================================

# adc_serial_rx_multi

Parametrised multi-channel serial ADC receiver with built-in sample-rate timing. It drives a shared chip-select and serial clock to a bank of 2-wire-style serial ADCs (one data line per channel). It shifts each frame in MSB first, strips the leading non-data bits, and presents all channels as one packed word with a one-cycle `listo` strobe. It runs single-shot (on `inicio`) or free-running at a parameterised sample rate (default ≈44.1 kHz from 100 MHz), and reports dropped conversion requests.

## Interface
- `WIDTH`, 12: data bits kept per channel.
- `LEAD`, 4: leading bits per frame discarded (ADC zero/garbage bits); frame length `FRAME = LEAD+WIDTH`.
- `CHANNELS`, 2: number of parallel ADC data lines, ≥1.
- `CLK_DIV`, 4: clk cycles per `sclk` half-period, ≥2 (default `sclk` = 12.5 MHz).
- `SAMPLE_PERIOD`, 2268: clk cycles between conversions in continuous mode (100 MHz / 2268 ≈ 44.09 kHz); must be ≥ `CLK_DIV*(2+2*FRAME)+2`.
- `clk100MHz`  in  1  system clock; all logic on its rising edge; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `datoADC`  in  `CHANNELS`  serial data; bit k from ADC k; changes after `sclk` falling edge.
- `inicio`  in  1  single-shot start request (level, sampled each cycle).
- `continuo`  in  1  1 = free-running at `SAMPLE_PERIOD`, 0 = single-shot.
- `sclk`  out  1  serial clock to ADCs, idles high.
- `CS`  out  1  chip select, active low.
- `dato_sin_basura`  out  `CHANNELS*WIDTH`  last completed sample; channel k at `[k*WIDTH +: WIDTH]`.
- `listo`  out  1  one-cycle strobe: `dato_sin_basura` updated this cycle.
- `ocupado`  out  1  high from CS fall until return to IDLE.
- `tick_muestreo`  out  1  one-cycle strobe of the internal sample-rate counter (continuous mode only).
- `perdido`  out  1  one-cycle strobe: a start request was rejected because the block was busy.

## Operation
- States: IDLE, START, SHIFT, DONE, QUIET.
- Start request is `inicio`=1 when `continuo`=0, or `tick_muestreo` when `continuo`=1 (`inicio` is ignored in continuous mode).
- IDLE: `CS`=1, `sclk`=1. On a start request, go to START next cycle.
- START: `CS`=0, `sclk`=1 for `CLK_DIV` cycles (CS setup), then go to SHIFT.
- SHIFT: `sclk` toggles every `CLK_DIV` cycles, beginning with a falling edge, for `FRAME` low/high pairs. In the cycle `sclk` goes 0→1, sample `datoADC` into each channel's `FRAME`-bit shift register, MSB first. After the `FRAME`-th rising edge, go to DONE.
- DONE (1 cycle): `CS`=1, `sclk`=1. Load each channel's low `WIDTH` bits into `dato_sin_basura`, discarding the `LEAD` MSBs regardless of their value. Pulse `listo`.
- QUIET: `CS`=1 for `CLK_DIV` cycles (minimum CS-high time), then go to IDLE.
- A start request in any state other than IDLE is dropped and `perdido` pulses. Requests are never queued.
- Sample-rate counter counts 0..`SAMPLE_PERIOD`-1 and pulses `tick_muestreo` at the wrap. It is held at 0 while `continuo`=0, so the first tick comes `SAMPLE_PERIOD` cycles after `continuo` rises.
- Clearing `continuo` mid-frame lets the current frame complete. Changing `datoADC` timing or mode never corrupts a frame in progress.

## Timing
- Reset values: `CS`=1, `sclk`=1, `dato_sin_basura`=0, `listo`=0, `ocupado`=0, `tick_muestreo`=0, `perdido`=0, state IDLE, counters 0.
- Reset asserted mid-frame: the next cycle shows reset values, including `CS`=1; the partial frame is discarded.
- Start request seen at cycle t: `CS` falls and `ocupado` rises at t+1.
- `listo` pulses at t+1+`CLK_DIV*(1+2*FRAME)` (defaults: t+133). `dato_sin_basura` is valid from that cycle and holds until the next `listo`.
- `ocupado` falls at t+2+`CLK_DIV*(2+2*FRAME)` (defaults: t+138). A request in that same cycle is accepted.
- Rising `sclk` edges fall at t+1+`CLK_DIV*(2i+2)` for i=0..FRAME-1; data is sampled in those cycles.
- Holding `inicio` high in single-shot mode starts back-to-back frames, one per IDLE entry, and pulses `perdido` every cycle while busy.

## Test plan
- Defaults, single-shot: ADC model streams ch0=0x0ABC and ch1=0x0123 MSB-first. Pulse `inicio` at t → `CS` low at t+1, 16 `sclk` rising edges, `listo` at t+133, `dato_sin_basura`=0x123ABC, `CS` high at t+133.
- Garbage stripping: ch0 stream 0xF001 → channel-0 field = 0x001; leading ones are ignored.
- Continuous: `continuo`=1 from reset release → `tick_muestreo` every 2268 cycles; each tick at t produces `listo` at t+133, with no `perdido`.
- Overrun: `SAMPLE_PERIOD`=100 (bench override, deliberately below the required minimum) → second tick falls mid-frame and `perdido` pulses. The frame is unaffected and the next accepted tick produces correct data.
- Reset mid-frame: assert `reset` at t+60 for 1 cycle → `CS`=1, `sclk`=1, `dato_sin_basura`=0 next cycle, no `listo`. A new `inicio` then yields a correct sample.
- Parameter sweep: `CHANNELS`=4, `WIDTH`=8, `LEAD`=2, `CLK_DIV`=2 → `listo` at t+1+42. The 32-bit packing matches each channel's model value.

Source files
------------

// File: rtl/adc_serial_rx_multi_if.sv
// rtl/adc_serial_rx_multi_if.sv - control, status and serial-bus bundle for the multi-channel ADC receiver
// Purpose: groups every non-clock/reset signal of adc_serial_rx_multi.
// Ports (signals):
//   datoADC          serial data, one line per channel (ADC -> receiver)
//   inicio/continuo  single-shot start request / free-running mode select
//   sclk/CS          serial clock (idles high) and active-low chip select
//   dato_sin_basura  packed sample, channel k at [k*WIDTH +: WIDTH]
//   listo            one-cycle strobe, dato_sin_basura updated
//   ocupado          high from CS fall until the receiver is idle again
//   tick_muestreo    one-cycle sample-rate strobe (continuous mode)
//   perdido          one-cycle strobe, start request rejected while busy
// Modports: master drives requests and ADC data, slave is the receiver.
interface adc_serial_rx_multi_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 12
);
    logic [CHANNELS-1:0]       datoADC;
    logic                      inicio;
    logic                      continuo;
    logic                      sclk;
    logic                      CS;
    logic [CHANNELS*WIDTH-1:0] dato_sin_basura;
    logic                      listo;
    logic                      ocupado;
    logic                      tick_muestreo;
    logic                      perdido;

    modport master (
        output datoADC, inicio, continuo,
        input  sclk, CS, dato_sin_basura, listo, ocupado, tick_muestreo, perdido
    );

    modport slave (
        input  datoADC, inicio, continuo,
        output sclk, CS, dato_sin_basura, listo, ocupado, tick_muestreo, perdido
    );
endinterface

// File: rtl/adc_serial_rx_multi.sv
// rtl/adc_serial_rx_multi.sv - multi-channel serial ADC receiver with sample-rate timer
// Purpose: drives shared CS/sclk to a bank of serial ADCs, shifts FRAME bits per
// channel MSB first, drops the LEAD leading bits and publishes all channels as
// one packed word with a listo strobe. Single-shot or free-running operation.
// Ports:
//   clk100MHz  system clock, rising edge
//   reset      synchronous, active-high
//   bus        adc_serial_rx_multi_if.slave (see interface file for signals)
module adc_serial_rx_multi #(
    parameter int WIDTH         = 12,
    parameter int LEAD          = 4,
    parameter int CHANNELS      = 2,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2268
) (
    input  logic                  clk100MHz,
    input  logic                  reset,
    adc_serial_rx_multi_if.slave  bus
);
    localparam int FRAME = LEAD + WIDTH;
    localparam int DW    = $clog2(CLK_DIV);
    localparam int BW    = $clog2(FRAME);
    localparam int SW    = $clog2(SAMPLE_PERIOD);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_QUIET = 3'd4;

    logic [2:0]                state;
    logic [DW-1:0]             div_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [SW-1:0]             rate_cnt;
    logic                      sclk_q;
    logic                      tick_q;
    logic [CHANNELS*WIDTH-1:0] dato_q;
    // Only the newest WIDTH bits are kept: the LEAD bits shift out the top.
    logic [WIDTH-1:0]          shreg [CHANNELS];

    logic div_end;
    logic start_req;

    assign div_end   = (div_cnt == DW'(CLK_DIV - 1));
    assign start_req = bus.continuo ? tick_q : bus.inicio;

    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk_q  <= 1'b1;
            dato_q  <= '0;
            for (int k = 0; k < CHANNELS; k++) shreg[k] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    div_cnt <= '0;
                    if (start_req) state <= S_START;
                end
                S_START: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        sclk_q  <= 1'b0;
                        state   <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_SHIFT: begin
                    // First cycle of the high phase is the rising-edge cycle.
                    if (sclk_q && div_cnt == '0) begin
                        for (int k = 0; k < CHANNELS; k++)
                            shreg[k] <= {shreg[k][WIDTH-2:0], bus.datoADC[k]};
                    end
                    if (div_end) begin
                        div_cnt <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else if (bit_cnt == BW'(FRAME - 1)) begin
                            // Publish on entry to DONE so the data is valid with listo.
                            for (int k = 0; k < CHANNELS; k++)
                                dato_q[k*WIDTH +: WIDTH] <= shreg[k];
                            state <= S_DONE;
                        end else begin
                            sclk_q  <= 1'b0;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_DONE: begin
                    div_cnt <= '0;
                    state   <= S_QUIET;
                end
                S_QUIET: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sample-rate timer, parked at zero outside continuous mode.
    always_ff @(posedge clk100MHz) begin
        if (reset || !bus.continuo) begin
            rate_cnt <= '0;
            tick_q   <= 1'b0;
        end else if (rate_cnt == SW'(SAMPLE_PERIOD - 1)) begin
            rate_cnt <= '0;
            tick_q   <= 1'b1;
        end else begin
            rate_cnt <= rate_cnt + SW'(1);
            tick_q   <= 1'b0;
        end
    end

    assign bus.sclk            = sclk_q;
    assign bus.CS              = !(state == S_START || state == S_SHIFT);
    assign bus.dato_sin_basura = dato_q;
    assign bus.listo           = (state == S_DONE);
    assign bus.ocupado         = (state != S_IDLE);
    assign bus.tick_muestreo   = tick_q;
    assign bus.perdido         = start_req && (state != S_IDLE);
endmodule

// File: tb/tb_adc_serial_rx_multi.sv
// tb/tb_adc_serial_rx_multi.sv - self-checking bench for adc_serial_rx_multi
module tb_adc_serial_rx_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic ra, rb, rc;
    logic sel;

    adc_serial_rx_multi_if #(.CHANNELS(2), .WIDTH(12)) ifa ();
    adc_serial_rx_multi_if #(.CHANNELS(2), .WIDTH(12)) ifb ();
    adc_serial_rx_multi_if #(.CHANNELS(4), .WIDTH(8))  ifc ();

    adc_serial_rx_multi u_a (.clk100MHz(clk), .reset(ra), .bus(ifa));
    adc_serial_rx_multi #(.SAMPLE_PERIOD(100)) u_b (.clk100MHz(clk), .reset(rb), .bus(ifb));
    adc_serial_rx_multi #(.CHANNELS(4), .WIDTH(8), .LEAD(2), .CLK_DIV(2)) u_c (.clk100MHz(clk), .reset(rc), .bus(ifc));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ADC models: each holds a frame word and puts the next bit out MSB first after every sclk fall.
    logic [15:0] wa [2];
    logic [15:0] wb [2];
    logic [9:0]  wc [4];
    int ia = 16, ib = 16, ic = 10;
    logic pa = 1'b1, pb = 1'b1, pc = 1'b1;

    always @(negedge clk) begin
        if (ifa.CS) ia = 16;
        else if (pa && !ifa.sclk && ia > 0) begin
            ia = ia - 1;
            for (int k = 0; k < 2; k++) ifa.datoADC[k] = wa[k][ia];
        end
        pa = ifa.sclk;
        if (ifb.CS) ib = 16;
        else if (pb && !ifb.sclk && ib > 0) begin
            ib = ib - 1;
            for (int k = 0; k < 2; k++) ifb.datoADC[k] = wb[k][ib];
        end
        pb = ifb.sclk;
        if (ifc.CS) ic = 10;
        else if (pc && !ifc.sclk && ic > 0) begin
            ic = ic - 1;
            for (int k = 0; k < 4; k++) ifc.datoADC[k] = wc[k][ic];
        end
        pc = ifc.sclk;
    end

    // Reference: packed word is each channel's word modulo 2^WIDTH, channel k at k*WIDTH.
    function automatic logic [63:0] exp_ab(input logic [15:0] w0, input logic [15:0] w1);
        logic [63:0] a0, a1;
        a0 = 64'(w0);
        a1 = 64'(w1);
        return (a1 % 4096) * 4096 + (a0 % 4096);
    endfunction

    function automatic logic [63:0] exp_c();
        logic [63:0] s;
        s = 0;
        for (int k = 0; k < 4; k++) s = s + ((64'(wc[k]) % 256) << (8 * k));
        return s;
    endfunction

    logic        m_tick, m_perd, m_listo;
    logic [23:0] m_dato;
    assign m_tick  = sel ? ifb.tick_muestreo : ifa.tick_muestreo;
    assign m_perd  = sel ? ifb.perdido : ifa.perdido;
    assign m_listo = sel ? ifb.listo : ifa.listo;
    assign m_dato  = sel ? ifb.dato_sin_basura : ifa.dato_sin_basura;

    int r_listo, r_free, r_rises, r_perd, r_listos;
    logic [23:0] r_dato;
    logic r_cs1, r_oc1, r_csl;

    // Single-shot run on instance a; cycle t is the one carrying the request.
    task automatic shot_a(input logic [15:0] w0, input logic [15:0] w1, input int rst_at, input int hold);
        logic ps;
        wa[0] = w0;
        wa[1] = w1;
        r_listo = -1; r_free = -1; r_rises = 0; r_perd = 0; r_listos = 0;
        r_dato = '0; r_cs1 = 1'bx; r_oc1 = 1'bx; r_csl = 1'bx;
        @(posedge clk); #1 ifa.inicio = 1'b1;
        @(negedge clk); ps = ifa.sclk;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            ifa.inicio = (n < hold);
            ra = (n == rst_at);
            @(negedge clk);
            if (n == 1) begin r_cs1 = ifa.CS; r_oc1 = ifa.ocupado; end
            if (!ps && ifa.sclk) r_rises++;
            ps = ifa.sclk;
            if (ifa.listo) begin
                r_listos++;
                if (r_listo < 0) begin r_listo = n; r_dato = ifa.dato_sin_basura; r_csl = ifa.CS; end
            end
            if (ifa.perdido) r_perd++;
            if (!ifa.ocupado && r_free < 0) r_free = n;
            if (n == rst_at + 1) begin
                chk("rst_mid_cs", ifa.CS, 1);
                chk("rst_mid_sclk", ifa.sclk, 1);
                chk("rst_mid_dato", ifa.dato_sin_basura, 0);
                chk("rst_mid_ocupado", ifa.ocupado, 0);
            end
        end
    endtask

    // Continuous-mode observer on instance selected by sel; n=0 is the first cycle out of reset.
    task automatic cont_run(input int nc, input int sp);
        int last_tick, busy_until, ticks, exp_perd, obs_perd;
        int exp_t [$];
        logic [63:0] want;
        last_tick = -1; busy_until = 0; ticks = 0; exp_perd = 0; obs_perd = 0;
        want = sel ? exp_ab(wb[0], wb[1]) : exp_ab(wa[0], wa[1]);
        for (int n = 0; n < nc; n++) begin
            @(negedge clk);
            if (m_tick) begin
                ticks++;
                chk("tick_spacing", n - last_tick, (last_tick < 0) ? sp + 1 : sp);
                last_tick = n;
                if (n >= busy_until) begin
                    exp_t.push_back(n + 133);
                    busy_until = n + 138;
                end else exp_perd++;
            end
            if (m_perd) obs_perd++;
            if (m_listo) begin
                if (exp_t.size() == 0) chk("cont_unexpected_listo", n, 0);
                else begin
                    chk("cont_listo_time", n, exp_t.pop_front());
                    chk("cont_dato", m_dato, want);
                end
            end
        end
        chk("cont_perdido_count", obs_perd, exp_perd);
        chk("cont_pending_listo", exp_t.size(), 0);
        chk("cont_tick_count", ticks, nc / sp);
    endtask

    task automatic shot_c();
        int nl;
        logic [31:0] d;
        for (int k = 0; k < 4; k++) wc[k] = 10'($urandom);
        nl = -1; d = '0;
        @(posedge clk); #1 ifc.inicio = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1 ifc.inicio = 1'b0;
            @(negedge clk);
            if (ifc.listo && nl < 0) begin nl = n; d = ifc.dato_sin_basura; end
        end
        chk("c_listo_time", nl, 43);
        chk("c_dato", d, exp_c());
    endtask

    initial begin
        sel = 1'b0;
        ra = 1'b1; rb = 1'b1; rc = 1'b1;
        ifa.inicio = 1'b0; ifa.continuo = 1'b0;
        ifb.inicio = 1'b0; ifb.continuo = 1'b0;
        ifc.inicio = 1'b0; ifc.continuo = 1'b0;
        wa[0] = '0; wa[1] = '0; wb[0] = '0; wb[1] = '0;
        for (int k = 0; k < 4; k++) wc[k] = '0;
        repeat (3) @(posedge clk);
        #1 ra = 1'b0; rc = 1'b0;
        @(negedge clk);
        chk("rst_cs", ifa.CS, 1);
        chk("rst_sclk", ifa.sclk, 1);
        chk("rst_dato", ifa.dato_sin_basura, 0);
        chk("rst_listo", ifa.listo, 0);
        chk("rst_ocupado", ifa.ocupado, 0);
        chk("rst_tick", ifa.tick_muestreo, 0);
        chk("rst_perdido", ifa.perdido, 0);
        chk("rst_c_dato", ifc.dato_sin_basura, 0);

        shot_a(16'h0ABC, 16'h0123, -1, 1);
        chk("basic_cs_fall", r_cs1, 0);
        chk("basic_ocupado_rise", r_oc1, 1);
        chk("basic_rises", r_rises, 16);
        chk("basic_listo_time", r_listo, 133);
        chk("basic_dato", r_dato, 24'h123ABC);
        chk("basic_cs_at_listo", r_csl, 1);
        chk("basic_ocupado_fall", r_free, 138);
        chk("basic_perdido", r_perd, 0);
        chk("basic_listo_count", r_listos, 1);

        begin
            logic [15:0] w1;
            w1 = 16'($urandom);
            shot_a(16'hF001, w1, -1, 1);
            chk("strip_dato", r_dato, exp_ab(16'hF001, w1));
        end

        for (int i = 0; i < 3; i++) begin
            logic [15:0] x0, x1;
            x0 = 16'($urandom);
            x1 = 16'($urandom);
            shot_a(x0, x1, -1, 1);
            chk("rand_listo_time", r_listo, 133);
            chk("rand_dato", r_dato, exp_ab(x0, x1));
        end

        shot_a(16'($urandom), 16'($urandom), 60, 1);
        chk("rst_mid_no_listo", r_listos, 0);
        chk("rst_mid_idle", r_free, 61);
        begin
            logic [15:0] x0, x1;
            x0 = 16'($urandom);
            x1 = 16'($urandom);
            shot_a(x0, x1, -1, 1);
            chk("after_rst_dato", r_dato, exp_ab(x0, x1));
            chk("after_rst_listo_time", r_listo, 133);
        end

        shot_a(16'($urandom), 16'($urandom), -1, 140);
        chk("hold_perdido_count", r_perd, 138);
        chk("hold_listo_count", r_listos, 2);
        chk("hold_rises", r_rises, 32);

        wa[0] = 16'($urandom); wa[1] = 16'($urandom);
        @(posedge clk); #1 ra = 1'b1; ifa.continuo = 1'b1;
        @(posedge clk); #1 ra = 1'b0;
        cont_run(3 * 2268 + 200, 2268);
        ifa.continuo = 1'b0;

        sel = 1'b1;
        wb[0] = 16'($urandom); wb[1] = 16'($urandom);
        @(posedge clk); #1 ifb.continuo = 1'b1;
        @(posedge clk); #1 rb = 1'b0;
        cont_run(450, 100);
        ifb.continuo = 1'b0;

        for (int i = 0; i < 3; i++) shot_c();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
